// File: rtl/keypad_pkg.sv
// keypad_pkg: shared scan-FSM state encoding and event payload for the keypad scanner.
`default_nettype none
package keypad_pkg;

  localparam int KEY_MAX_W = 8;

  typedef enum logic [1:0] {
    ST_SETTLE = 2'd0,
    ST_SAMPLE = 2'd1,
    ST_EMIT   = 2'd2
  } state_e;

  typedef struct packed {
    logic [KEY_MAX_W-1:0] key;
    logic                 press;
  } evt_t;

endpackage
`default_nettype wire

// File: rtl/evt_fifo.sv
// evt_fifo: show-ahead event queue; a push while full is refused even if a pop happens.
`default_nettype none
module evt_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  T              data_i,
  input  logic          pop_i,
  output T              data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  T              mem_q [DEPTH];
  logic [PW-1:0] wr_q;
  logic [PW-1:0] rd_q;
  logic [CW-1:0] count_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + PW'(1);
      if (do_pop)  rd_q <= rd_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_q];
  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/keypad_scanner.sv
// keypad_scanner: column-scanned keypad with per-key debounce and a press/release event queue.
`default_nettype none
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int  ROWS       = 4,
  parameter int  COLS       = 4,
  parameter int  SETTLE     = 15,
  parameter int  DEBOUNCE   = 4,
  parameter int  FIFO_DEPTH = 4,
  localparam int KEYS       = ROWS * COLS,
  localparam int KW         = $clog2(KEYS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [ROWS-1:0] row_i,
  output logic [COLS-1:0] col_o,
  output logic [KEYS-1:0] keys_o,
  output logic            evt_valid,
  input  logic            evt_ready,
  output logic [KW-1:0]   evt_key,
  output logic            evt_press,
  output logic            overflow,
  input  logic            clr_overflow
);

  localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CIW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int SW  = $clog2(SETTLE + 1);
  localparam int DW  = $clog2(DEBOUNCE + 1);
  localparam int FCW = $clog2(FIFO_DEPTH + 1);

  state_e          state_q, state_d;
  logic [CIW-1:0]  c_q, c_d;
  logic [RW-1:0]   r_q, r_d;
  logic [SW-1:0]   settle_q, settle_d;
  logic [ROWS-1:0] sample_q, sample_d;
  logic [KEYS-1:0] keys_q, keys_d;
  logic [DW-1:0]   cnt_q [KEYS];
  logic [DW-1:0]   cnt_d [KEYS];
  logic            overflow_q, overflow_d;

  logic [KW-1:0]   key_idx;
  logic [DW-1:0]   cnt_inc;
  logic            push;
  evt_t            ev;
  evt_t            head;
  logic            full;
  logic            empty;
  logic            pop;
  logic [FCW-1:0]  unused_count;
  logic [KEY_MAX_W-KW-1:0] unused_key_hi;

  always_comb begin
    state_d    = state_q;
    c_d        = c_q;
    r_d        = r_q;
    settle_d   = settle_q;
    sample_d   = sample_q;
    keys_d     = keys_q;
    cnt_d      = cnt_q;
    overflow_d = overflow_q;
    push       = 1'b0;
    ev         = '0;
    cnt_inc    = '0;
    key_idx    = KW'(int'(r_q) * COLS + int'(c_q));

    case (state_q)
      ST_SETTLE: begin
        if (settle_q == SW'(SETTLE - 1)) begin
          settle_d = '0;
          state_d  = ST_SAMPLE;
        end else begin
          settle_d = settle_q + SW'(1);
        end
      end
      ST_SAMPLE: begin
        sample_d = ~row_i;
        r_d      = '0;
        state_d  = ST_EMIT;
      end
      ST_EMIT: begin
        // One key per cycle, so at most one event can be generated here.
        if (sample_q[r_q] == keys_q[key_idx]) begin
          cnt_d[key_idx] = '0;
        end else begin
          cnt_inc = cnt_q[key_idx] + DW'(1);
          if (cnt_inc == DW'(DEBOUNCE)) begin
            keys_d[key_idx] = ~keys_q[key_idx];
            cnt_d[key_idx]  = '0;
            push            = 1'b1;
            ev.key          = KEY_MAX_W'(key_idx);
            ev.press        = ~keys_q[key_idx];
          end else begin
            cnt_d[key_idx] = cnt_inc;
          end
        end
        if (r_q == RW'(ROWS - 1)) begin
          r_d     = '0;
          c_d     = (c_q == CIW'(COLS - 1)) ? '0 : c_q + CIW'(1);
          state_d = ST_SETTLE;
        end else begin
          r_d = r_q + RW'(1);
        end
      end
      default: state_d = ST_SETTLE;
    endcase

    // A drop in the same cycle as a clear request keeps the flag set.
    if (push && full)      overflow_d = 1'b1;
    else if (clr_overflow) overflow_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_SETTLE;
      c_q        <= '0;
      r_q        <= '0;
      settle_q   <= '0;
      sample_q   <= '0;
      keys_q     <= '0;
      cnt_q      <= '{default: '0};
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      c_q        <= c_d;
      r_q        <= r_d;
      settle_q   <= settle_d;
      sample_q   <= sample_d;
      keys_q     <= keys_d;
      cnt_q      <= cnt_d;
      overflow_q <= overflow_d;
    end
  end

  evt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (evt_t)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .data_i  (ev),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (unused_count)
  );

  assign pop           = evt_valid && evt_ready;
  assign evt_valid     = ~empty;
  assign evt_key       = head.key[KW-1:0];
  assign evt_press     = head.press;
  assign unused_key_hi = head.key[KEY_MAX_W-1:KW];
  assign keys_o        = keys_q;
  assign overflow      = overflow_q;
  assign col_o         = rst ? '1 : ~(COLS'(1) << c_q);

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed checks of scan timing, debounce, event queue, overflow and reset.
`default_nettype none
module tb_keypad_scanner;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  row_i;
  logic [3:0]  col_o;
  logic [15:0] keys_o;
  logic        evt_valid;
  logic        evt_ready = 1'b1;
  logic [3:0]  evt_key;
  logic        evt_press;
  logic        overflow;
  logic        clr_overflow = 1'b0;
  logic [15:0] pressed = '0;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int log_key[$];
  int log_press[$];
  int log_cyc[$];

  always #5 clk = ~clk;

  keypad_scanner dut (
    .clk          (clk),
    .rst          (rst),
    .row_i        (row_i),
    .col_o        (col_o),
    .keys_o       (keys_o),
    .evt_valid    (evt_valid),
    .evt_ready    (evt_ready),
    .evt_key      (evt_key),
    .evt_press    (evt_press),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
  );

  // Switch matrix: a pressed key pulls its row low while its column is driven low.
  always_comb begin
    row_i = '1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!col_o[c] && pressed[r*4+c]) row_i[r] = 1'b0;
  end

  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  always @(posedge clk) begin
    if (!rst && evt_valid && evt_ready) begin
      log_key.push_back(int'(evt_key));
      log_press.push_back(int'(evt_press));
      log_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_to(input int t);
    int g = 0;
    while (cyc != t && g < 5000) begin
      @(negedge clk);
      g++;
    end
    if (cyc != t) chk("run_to_timeout", cyc, t);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    log_key.delete();
    log_press.delete();
    log_cyc.delete();
    rst = 1'b0;
  endtask

  function automatic int qget(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  initial begin
    // Reset values, then key 6 held from reset.
    pressed = 16'h0040;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_col", col_o, 4'hf);
    chk("rst_valid", evt_valid, 1'b0);
    chk("rst_keys", keys_o, 16'h0000);
    chk("rst_ovf", overflow, 1'b0);
    rst = 1'b0;
    #1;
    chk("col_first", col_o, 4'he);
    run_to(15);  chk("col_sample0", col_o, 4'he);
    run_to(19);  chk("col_emit0", col_o, 4'he);
    run_to(20);  chk("col_settle1", col_o, 4'hd);
    run_to(60);  chk("col_settle3", col_o, 4'h7);
    run_to(80);  chk("col_wrap", col_o, 4'he);
    run_to(297); chk("k6_keys_before", keys_o, 16'h0000);
    chk("k6_valid_before", evt_valid, 1'b0);
    run_to(298); chk("k6_valid", evt_valid, 1'b1);
    chk("k6_key", evt_key, 4'd6);
    chk("k6_press", evt_press, 1'b1);
    chk("k6_keys", keys_o, 16'h0040);
    run_to(400); chk("k6_count", log_key.size(), 1);
    chk("k6_log_cyc", qget(log_cyc, 0), 298);

    // Key 6 bounces for 3 scans twice; counter must clear in between.
    pressed = 16'h0040;
    do_reset();
    run_to(250); pressed = 16'h0000;
    run_to(400); pressed = 16'h0040;
    run_to(630); pressed = 16'h0000;
    run_to(800);
    chk("bounce_keys", keys_o, 16'h0000);
    chk("bounce_events", log_key.size(), 0);

    // Column 0 pressed together: four events on consecutive cycles.
    pressed = 16'h1111;
    do_reset();
    run_to(261);
    chk("col0_count", log_key.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("col0_key%0d", i), qget(log_key, i), 4 * i);
      chk($sformatf("col0_cyc%0d", i), qget(log_cyc, i), 257 + i);
      chk($sformatf("col0_press%0d", i), qget(log_press, i), 1);
    end
    chk("col0_keys", keys_o, 16'h1111);

    // Five presses with consumer stalled: fifth event dropped.
    evt_ready = 1'b0;
    pressed   = 16'h1113;
    do_reset();
    run_to(275); chk("ovf_before", overflow, 1'b0);
    run_to(277); chk("ovf_set", overflow, 1'b1);
    chk("ovf_keys", keys_o, 16'h1113);
    chk("ovf_head", evt_key, 4'd0);
    chk("ovf_valid", evt_valid, 1'b1);
    run_to(280); evt_ready = 1'b1;
    run_to(284);
    chk("drain_valid", evt_valid, 1'b0);
    chk("drain_count", log_key.size(), 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("drain_key%0d", i), qget(log_key, i), 4 * i);
    chk("drain_cyc3", qget(log_cyc, 3), 283);

    // Overflow clear, then clear colliding with a new drop.
    run_to(285); evt_ready = 1'b0;
    run_to(290); pressed = 16'h0000; clr_overflow = 1'b1;
    run_to(291); clr_overflow = 1'b0;
    chk("clr_alone1", overflow, 1'b0);
    run_to(580);
    chk("rel_valid", evt_valid, 1'b1);
    chk("rel_key", evt_key, 4'd0);
    chk("rel_press", evt_press, 1'b0);
    run_to(596); chk("ovf_pre_drop", overflow, 1'b0);
    clr_overflow = 1'b1;
    run_to(597); clr_overflow = 1'b0;
    chk("clr_vs_drop", overflow, 1'b1);
    chk("rel_keys", keys_o, 16'h0000);
    run_to(600); chk("ovf_hold", overflow, 1'b1);
    clr_overflow = 1'b1;
    run_to(601); clr_overflow = 1'b0;
    chk("clr_alone2", overflow, 1'b0);

    // Reset during EMIT of column 3 with two queued events.
    evt_ready = 1'b0;
    pressed   = 16'h0011;
    do_reset();
    run_to(317);
    chk("mid_valid", evt_valid, 1'b1);
    chk("mid_keys", keys_o, 16'h0011);
    chk("mid_col", col_o, 4'h7);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", evt_valid, 1'b0);
    chk("mid_rst_keys", keys_o, 16'h0000);
    chk("mid_rst_col", col_o, 4'hf);
    pressed   = 16'h0000;
    evt_ready = 1'b1;
    @(negedge clk);
    log_key.delete();
    log_press.delete();
    log_cyc.delete();
    rst = 1'b0;
    #1;
    chk("mid_after_col", col_o, 4'he);
    run_to(400);
    chk("mid_no_events", log_key.size(), 0);
    chk("mid_after_keys", keys_o, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
